unsigned_down_load_counter: RTL

Loadable unsigned down counter with asynchronous clear, count enable, terminal-count decode and a one-cycle underflow pulse. It is the count-down counterpart of the team's unsigned up counter. It serves as the timeout / interval element in timer and pacing logic, where a value is loaded, counted to zero and the underflow event is consumed downstream. Optional auto-reload turns it into a periodic interval generator.

---
 rtl/unsigned_down_load_counter.sv | 63 ++++++
 1 files changed

// File: rtl/unsigned_down_load_counter.sv
// Loadable unsigned down counter with async clear, terminal-count decode and underflow pulse.
// Define UNSIGNED_DOWN_COUNTER_AUTO_RELOAD_EN to reload the last loaded value on underflow.
module unsigned_down_load_counter #(
   parameter int WIDTH = 4
) (
   input  logic             C,
   input  logic             CLR,
   input  logic             LD,
   input  logic [WIDTH-1:0] D,
   input  logic             CE,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             UF,
   output logic             UFS
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] wrap_value;

`ifdef UNSIGNED_DOWN_COUNTER_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload;

   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         reload <= '0;
      end else if (LD) begin
         reload <= D;
      end
   end

   assign wrap_value = reload;
`else
   assign wrap_value = '1;
`endif

   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         Q   <= '0;
         UF  <= 1'b0;
         UFS <= 1'b0;
      end else if (LD) begin
         Q   <= D;
         UF  <= 1'b0;
         UFS <= 1'b0;
      end else if (CE) begin
         if (Q == '0) begin
            // underflow: next value comes from the reload register or wraps to all ones
            Q   <= wrap_value;
            UF  <= 1'b1;
            UFS <= 1'b1;
         end else begin
            Q   <= Q - ONE;
            UF  <= 1'b0;
         end
      end else begin
         UF <= 1'b0;
      end
   end

   assign TC = (Q == '0);

endmodule
